// File: rtl/l1_mem_pkg.sv
// Shared types for the L1 memory arbiter: FSM states, request owner and
// default bus widths.
package l1_mem_pkg;

  localparam int L1_ADDR_W = 32;
  localparam int L1_DATA_W = 32;
  localparam int L1_WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/l1_rr_arbiter.sv
// Two-way grant select between icache and dcache misses. Fixed dcache
// priority by default; round-robin on ties when RR_ARB_EN is defined.
module l1_rr_arbiter
  import l1_mem_pkg::*;
(
`ifdef RR_ARB_EN
  input  logic clk,
  input  logic reset,
  input  logic grant,
`endif
  input  logic ic_req,
  input  logic dc_req,
  output logic gnt_valid,
  output logic gnt_dc
);

  logic prefer_dc_s;

`ifdef RR_ARB_EN
  owner_e last_owner_r;

  // Remember who was granted last so the other side wins the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_r <= OWN_IC;
    end else if (grant) begin
      last_owner_r <= gnt_dc ? OWN_DC : OWN_IC;
    end
  end

  assign prefer_dc_s = (last_owner_r == OWN_IC);
`else
  assign prefer_dc_s = 1'b1;
`endif

  // Grant decode: a lone requester always wins, ties use the preference.
  always_comb begin
    gnt_valid = ic_req | dc_req;
    if (ic_req && dc_req) begin
      gnt_dc = prefer_dc_s;
    end else begin
      gnt_dc = dc_req;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one main-memory port between icache and dcache misses: optional
// victim writeback, then refill read. Define RR_ARB_EN for round-robin ties.
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W   = L1_ADDR_W,
  parameter int DATA_W   = L1_DATA_W,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_wb,
  input  logic [ADDR_W-1:0] dc_wb_addr,
  input  logic [DATA_W-1:0] dc_wb_data,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err
);

  localparam logic [L1_WAIT_W-1:0] WAIT_LAST = L1_WAIT_W'(MAX_WAIT - 1);
  localparam logic [L1_WAIT_W-1:0] WAIT_ZERO = {L1_WAIT_W{1'b0}};
  localparam logic [L1_WAIT_W-1:0] WAIT_ONE  = L1_WAIT_W'(1);
  localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0]    DATA_ZERO = {DATA_W{1'b0}};

  state_e               state_r,    state_s;
  owner_e               owner_r,    owner_s;
  logic                 gap_r,      gap_s;
  logic [ADDR_W-1:0]    rd_addr_r,  rd_addr_s;
  logic [ADDR_W-1:0]    wb_addr_r,  wb_addr_s;
  logic [DATA_W-1:0]    wb_data_r,  wb_data_s;
  logic [L1_WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic                 err_r,      err_s;
  logic [DATA_W-1:0]    ic_rdata_r, ic_rdata_s;
  logic [DATA_W-1:0]    dc_rdata_r, dc_rdata_s;
  logic                 ic_done_r,  ic_done_s;
  logic                 dc_done_r,  dc_done_s;
  logic                 mem_ren_r,  mem_ren_s;
  logic                 mem_wen_r,  mem_wen_s;
  logic [ADDR_W-1:0]    mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0]    mem_wdata_r, mem_wdata_s;
  logic                 gnt_valid_s;
  logic                 gnt_dc_s;
  logic                 timeout_s;

`ifdef RR_ARB_EN
  logic grant_s;
  assign grant_s = (state_r == IDLE) & gnt_valid_s;
`endif

  l1_rr_arbiter u_arb (
`ifdef RR_ARB_EN
    .clk       (clk),
    .reset     (reset),
    .grant     (grant_s),
`endif
    .ic_req    (ic_req),
    .dc_req    (dc_req),
    .gnt_valid (gnt_valid_s),
    .gnt_dc    (gnt_dc_s)
  );

  assign timeout_s = (wait_cnt_r == WAIT_LAST);

  // Next-state, latch and output decode for the miss sequencer.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    gap_s      = 1'b0;
    rd_addr_s  = rd_addr_r;
    wb_addr_s  = wb_addr_r;
    wb_data_s  = wb_data_r;
    wait_cnt_s = wait_cnt_r;
    err_s      = err_r;
    ic_rdata_s = ic_rdata_r;
    dc_rdata_s = dc_rdata_r;

    case (state_r)
      IDLE: begin
        wait_cnt_s = WAIT_ZERO;
        if (gnt_valid_s) begin
          if (gnt_dc_s) begin
            owner_s   = OWN_DC;
            rd_addr_s = dc_addr;
            wb_addr_s = dc_wb_addr;
            wb_data_s = dc_wb_data;
            state_s   = dc_wb ? WB : RD;
          end else begin
            owner_s   = OWN_IC;
            rd_addr_s = ic_addr;
            state_s   = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WB: begin
        if (mem_ready) begin
          state_s    = RD;
          gap_s      = 1'b1;
          wait_cnt_s = WAIT_ZERO;
        end else if (timeout_s) begin
          state_s    = DONE;
          err_s      = 1'b1;
          wait_cnt_s = WAIT_ZERO;
          if (owner_r == OWN_DC) begin
            dc_rdata_s = DATA_ZERO;
          end else begin
            ic_rdata_s = DATA_ZERO;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end
      end

      RD: begin
        // The first RD cycle after a writeback is a dead cycle on the bus.
        if (gap_r) begin
          state_s = RD;
        end else if (mem_ready) begin
          state_s    = DONE;
          wait_cnt_s = WAIT_ZERO;
          if (owner_r == OWN_DC) begin
            dc_rdata_s = mem_rdata;
          end else begin
            ic_rdata_s = mem_rdata;
          end
        end else if (timeout_s) begin
          state_s    = DONE;
          err_s      = 1'b1;
          wait_cnt_s = WAIT_ZERO;
          if (owner_r == OWN_DC) begin
            dc_rdata_s = DATA_ZERO;
          end else begin
            ic_rdata_s = DATA_ZERO;
          end
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_ONE;
        end
      end

      DONE: begin
        state_s    = IDLE;
        wait_cnt_s = WAIT_ZERO;
      end

      default: begin
        state_s    = IDLE;
        wait_cnt_s = WAIT_ZERO;
      end
    endcase

    ic_done_s = (state_s == DONE) && (owner_s == OWN_IC);
    dc_done_s = (state_s == DONE) && (owner_s == OWN_DC);
    mem_wen_s = (state_s == WB);
    mem_ren_s = (state_s == RD) && !gap_s;

    if (mem_wen_s) begin
      mem_addr_s  = wb_addr_s;
      mem_wdata_s = wb_data_s;
    end else if (mem_ren_s) begin
      mem_addr_s  = rd_addr_s;
      mem_wdata_s = DATA_ZERO;
    end else begin
      mem_addr_s  = ADDR_ZERO;
      mem_wdata_s = DATA_ZERO;
    end
  end

  // State, grant latch and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= OWN_IC;
      gap_r       <= 1'b0;
      rd_addr_r   <= ADDR_ZERO;
      wb_addr_r   <= ADDR_ZERO;
      wb_data_r   <= DATA_ZERO;
      wait_cnt_r  <= WAIT_ZERO;
      err_r       <= 1'b0;
      ic_rdata_r  <= DATA_ZERO;
      dc_rdata_r  <= DATA_ZERO;
      ic_done_r   <= 1'b0;
      dc_done_r   <= 1'b0;
      mem_ren_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= ADDR_ZERO;
      mem_wdata_r <= DATA_ZERO;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      gap_r       <= gap_s;
      rd_addr_r   <= rd_addr_s;
      wb_addr_r   <= wb_addr_s;
      wb_data_r   <= wb_data_s;
      wait_cnt_r  <= wait_cnt_s;
      err_r       <= err_s;
      ic_rdata_r  <= ic_rdata_s;
      dc_rdata_r  <= dc_rdata_s;
      ic_done_r   <= ic_done_s;
      dc_done_r   <= dc_done_s;
      mem_ren_r   <= mem_ren_s;
      mem_wen_r   <= mem_wen_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign ic_rdata  = ic_rdata_r;
  assign ic_done   = ic_done_r;
  assign dc_rdata  = dc_rdata_r;
  assign dc_done   = dc_done_r;
  assign mem_ren   = mem_ren_r;
  assign mem_wen   = mem_wen_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign err       = err_r;
  assign stall     = (ic_req | dc_req) & ~(ic_done_r | dc_done_r);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed self-checking bench for l1_mem_arbiter (MAX_WAIT shortened to 8).
module tb_l1_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, dc_wb, mem_ready;
  logic [31:0] ic_addr, dc_addr, dc_wb_addr, dc_wb_data, mem_rdata;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic        ic_done, dc_done, mem_ren, mem_wen, stall, err;

  int tests_run    = 0;
  int tests_failed = 0;
  int wen_cycles   = 0;
  int overlap_cycles = 0;
  int ren_cycles;

`ifdef RR_ARB_EN
  localparam logic MID_DC_FIRST = 1'b0;
`else
  localparam logic MID_DC_FIRST = 1'b1;
`endif

  always #5 clk = ~clk;

  l1_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_rdata   (ic_rdata),
    .ic_done    (ic_done),
    .dc_req     (dc_req),
    .dc_addr    (dc_addr),
    .dc_wb      (dc_wb),
    .dc_wb_addr (dc_wb_addr),
    .dc_wb_data (dc_wb_data),
    .dc_rdata   (dc_rdata),
    .dc_done    (dc_done),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .stall      (stall),
    .err        (err)
  );

  // Bus monitor: count write strobes and any read/write overlap.
  always @(posedge clk) begin
    if (mem_wen) wen_cycles <= wen_cycles + 1;
    if (mem_ren && mem_wen) overlap_cycles <= overlap_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Simultaneous ic/dc misses, no writeback; dc_first selects the expected winner.
  task automatic run_tie(input logic dc_first, input logic [31:0] a_ic, input logic [31:0] a_dc,
                         input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] first_addr, second_addr;
    first_addr  = dc_first ? a_dc : a_ic;
    second_addr = dc_first ? a_ic : a_dc;
    ic_req = 1'b1; dc_req = 1'b1; dc_wb = 1'b0; ic_addr = a_ic; dc_addr = a_dc;
    tick;
    check("tie_first_ren", mem_ren, 1);
    check("tie_first_addr", mem_addr, first_addr);
    mem_ready = 1'b1; mem_rdata = d1;
    tick;
    mem_ready = 1'b0;
    check("tie_first_dc_done", dc_done, dc_first);
    check("tie_first_ic_done", ic_done, !dc_first);
    check("tie_first_rdata", dc_first ? dc_rdata : ic_rdata, d1);
    if (dc_first) dc_req = 1'b0; else ic_req = 1'b0;
    tick;
    check("tie_idle_gap", mem_ren, 0);
    tick;
    check("tie_second_ren", mem_ren, 1);
    check("tie_second_addr", mem_addr, second_addr);
    mem_ready = 1'b1; mem_rdata = d2;
    tick;
    mem_ready = 1'b0;
    check("tie_second_dc_done", dc_done, !dc_first);
    check("tie_second_ic_done", ic_done, dc_first);
    check("tie_second_rdata", dc_first ? ic_rdata : dc_rdata, d2);
    ic_req = 1'b0; dc_req = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_wb = 1'b0; mem_ready = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0; dc_wb_addr = 32'h0; dc_wb_data = 32'h0; mem_rdata = 32'h0;
    #3;
    check("rst_ren", mem_ren, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_done", {30'h0, ic_done, dc_done}, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick;

    // icache refill, memory answers two cycles after the read strobe
    ic_req = 1'b1; ic_addr = 32'h40;
    #1;
    check("t1_stall_req", stall, 1);
    tick;
    check("t1_ren", mem_ren, 1);
    check("t1_addr", mem_addr, 32'h40);
    tick;
    check("t1_ren_hold", mem_ren, 1);
    check("t1_stall_wait", stall, 1);
    tick;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    check("t1_ic_done", ic_done, 1);
    check("t1_ic_rdata", ic_rdata, 32'hDEADBEEF);
    check("t1_ren_drop", mem_ren, 0);
    check("t1_stall_done", stall, 0);
    tick;
    ic_req = 1'b0;
    check("t1_done_pulse", ic_done, 0);
    tick;
    check("t1_no_regrant", mem_ren, 0);
    check("t1_no_wen", wen_cycles, 0);

    // dcache miss with dirty victim
    dc_req = 1'b1; dc_wb = 1'b1; dc_wb_addr = 32'h10; dc_wb_data = 32'h12345678; dc_addr = 32'h18;
    tick;
    check("t2_wen", mem_wen, 1);
    check("t2_ren_off", mem_ren, 0);
    check("t2_wb_addr", mem_addr, 32'h10);
    check("t2_wb_data", mem_wdata, 32'h12345678);
    dc_wb_addr = 32'h0; dc_wb_data = 32'h0;
    tick;
    check("t2_wb_data_stable", mem_wdata, 32'h12345678);
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    check("t2_gap", {30'h0, mem_ren, mem_wen}, 0);
    tick;
    check("t2_ren", mem_ren, 1);
    check("t2_rd_addr", mem_addr, 32'h18);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick;
    mem_ready = 1'b0;
    check("t2_dc_done", dc_done, 1);
    check("t2_dc_rdata", dc_rdata, 32'hCAFEF00D);
    check("t2_ic_quiet", ic_done, 0);
    dc_req = 1'b0; dc_wb = 1'b0;
    tick;
    check("t2_done_pulse", dc_done, 0);

    // simultaneous requests
    run_tie(MID_DC_FIRST, 32'h100, 32'h200, 32'h11111111, 32'h22222222);
    run_tie(MID_DC_FIRST, 32'h104, 32'h204, 32'h33333333, 32'h44444444);

    // timeout: memory never answers
    check("t4_err_before", err, 0);
    ic_req = 1'b1; ic_addr = 32'h80;
    ren_cycles = 0;
    for (int g = 0; g < 40 && !ic_done; g++) begin
      tick;
      if (mem_ren) ren_cycles++;
    end
    check("t4_done", ic_done, 1);
    check("t4_ren_cycles", ren_cycles, 8);
    check("t4_err", err, 1);
    check("t4_rdata_zero", ic_rdata, 32'h0);
    ic_req = 1'b0;
    tick;
    tick;
    check("t4_err_sticky", err, 1);
    check("t4_idle", mem_ren, 0);

    // reset in the middle of a writeback
    dc_req = 1'b1; dc_wb = 1'b1; dc_wb_addr = 32'h30; dc_wb_data = 32'hA5A5A5A5; dc_addr = 32'h38;
    tick;
    check("t5_wen", mem_wen, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_wen_async", mem_wen, 0);
    check("t5_err_clr", err, 0);
    dc_req = 1'b0; dc_wb = 1'b0;
    tick;
    check("t5_no_done", dc_done, 0);
    reset = 1'b0;
    tick;
    check("t5_no_done_after", dc_done, 0);
    check("t5_quiet", {30'h0, mem_ren, mem_wen}, 0);

    // first tie after reset goes to dcache in both builds
    run_tie(1'b1, 32'h108, 32'h208, 32'h55555555, 32'h66666666);

    dc_req = 1'b1; dc_addr = 32'h44;
    tick;
    check("t6_ren", mem_ren, 1);
    check("t6_addr", mem_addr, 32'h44);
    mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    tick;
    mem_ready = 1'b0;
    check("t6_dc_done", dc_done, 1);
    check("t6_dc_rdata", dc_rdata, 32'h0BADF00D);
    check("t6_err", err, 0);
    dc_req = 1'b0;
    tick;
    check("no_overlap", overlap_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
Shares the single main-memory port between the instruction cache and the data cache.
- Sequences each miss: optional dirty-victim writeback first, then line refill read.
- Returns refill data to the requester with a one-cycle done pulse and drives a global pipeline stall while any miss is outstanding.
- Sits between both L1 caches and main memory. Addresses are word addresses, line = one 32-bit word.

Parameters:
ADDR_W, 32, word-address width on every port
DATA_W, 32, data word width
MAX_WAIT, 255, cycles to wait for mem_ready before aborting with err (8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
ic_req  in  1  icache miss request, level, held until ic_done
ic_addr  in  ADDR_W  icache refill address
ic_rdata  out  DATA_W  refill data, valid while ic_done=1
ic_done  out  1  one-cycle completion pulse
dc_req  in  1  dcache miss request, level, held until dc_done
dc_addr  in  ADDR_W  dcache refill address
dc_wb  in  1  victim dirty, writeback required (sampled with dc_req at grant)
dc_wb_addr  in  ADDR_W  victim address
dc_wb_data  in  DATA_W  victim data
dc_rdata  out  DATA_W  refill data, valid while dc_done=1
dc_done  out  1  one-cycle completion pulse
mem_ren  out  1  memory read strobe, held until mem_ready
mem_wen  out  1  memory write strobe, held until mem_ready
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
mem_ready  in  1  one-cycle completion from memory
stall  out  1  combinational: (ic_req|dc_req) & ~(ic_done|dc_done)
err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except stall, which follows its equation; grant latch cleared; wait counter 0.
- FSM states: IDLE, WB, RD, DONE.
- IDLE, arbitration (default build): dcache has fixed priority over icache.
  - Grant latches owner, address, dc_wb, dc_wb_addr and dc_wb_data.
  - Granted dcache with dc_wb=1 -> WB; otherwise -> RD.
  - Latency from req to first strobe: 1 cycle.
- WB: mem_wen=1, mem_addr=wb_addr, mem_wdata=wb_data.
  - On mem_ready -> RD, strobes drop for exactly 1 cycle.
- RD: mem_ren=1, mem_addr=latched refill address.
  - On mem_ready: capture mem_rdata into the owner's rdata register -> DONE.
- DONE: owner's done=1 for exactly 1 cycle, rdata held stable -> IDLE.
  - Requests are ignored in the DONE cycle. The requester drops req in the cycle after done.
  - Arbitration resumes in IDLE on the following cycle.
- Back-to-back: if both requests are pending, icache is granted in the IDLE cycle after dcache completes. Minimum miss = 3 cycles + memory latency.
- mem_ren and mem_wen are never high together. Address and data are stable while a strobe is high.
- Timeout: the counter increments each cycle in WB or RD while mem_ready=0.
  - On reaching MAX_WAIT: err<=1, owner's done pulses with rdata=0, FSM -> IDLE.
  - The counter clears on every state change.
- mem_ready outside WB or RD is ignored.
- Requester dropping req mid-transaction: the transaction still completes and done still pulses.
- Reset mid-transaction aborts immediately: strobes drop and no done pulse is issued.

Optional Feature:
RR_ARB_EN
- Defined: round-robin arbitration. A last-owner bit gives priority to the other requester when both are pending. The bit resets to icache, so dcache wins the first tie.
- Undefined: fixed dcache priority as above.
- Single-requester timing is identical in both builds.

Decomposition:
Shared package l1_mem_pkg:
- state enum (IDLE, WB, RD, DONE)
- owner enum (OWN_IC, OWN_DC)
- ADDR_W and DATA_W defaults

Sub-module l1_rr_arbiter: 2-input grant logic with fixed/round-robin select under RR_ARB_EN, purely combinational plus the last-owner flop.

Test Plan:
- ic_req=1, ic_addr=0x40, mem_ready 2 cycles after mem_ren, mem_rdata=0xDEADBEEF -> mem_ren/mem_addr=0x40 one cycle after req; ic_done pulses 1 cycle with ic_rdata=0xDEADBEEF; mem_wen never high.
- dc_req=1, dc_wb=1, dc_wb_addr=0x10, dc_wb_data=0x12345678, dc_addr=0x18 -> mem_wen with 0x10/0x12345678, then a 1-cycle gap, then mem_ren at 0x18, then dc_done.
- ic_req and dc_req asserted in the same cycle (default build) -> dcache served first, icache next; with RR_ARB_EN, a second simultaneous pair is served icache first.
- mem_ready held 0 with MAX_WAIT=8 -> err=1 after 8 cycles in RD, done pulses with rdata=0, FSM back in IDLE, err stays 1.
- reset asserted during WB -> mem_wen drops asynchronously, no done pulse, err=0; a new dc_req after reset completes normally.
- stall check -> stall=1 from req through the cycle before done, 0 in the done cycle.
